// File: rtl/rr_resource_sched.sv
// Round-robin owner scheduler for one shared single-owner resource.
// Ports: i_clk, i_rst_n (sync, active low), i_req[N], i_done ->
//        o_gnt[N] one-hot, o_gnt_vld, o_gnt_id[ID_W], o_timeout pulse.
module rr_resource_sched #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int ID_W     = $clog2(N)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N-1:0]    i_req,
    input  logic            i_done,
    output logic [N-1:0]    o_gnt,
    output logic            o_gnt_vld,
    output logic [ID_W-1:0] o_gnt_id,
    output logic            o_timeout
);

    localparam int HC_W = $clog2(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0] ID_LAST   = ID_W'(N - 1);
    localparam logic [N-1:0]    ONE       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_gnt;
    logic            r_gnt_vld;
    logic [ID_W-1:0] r_gnt_id;
    logic            r_timeout;
    logic [ID_W-1:0] r_ptr;
    logic [HC_W-1:0] r_hold_cnt;

    state_t          w_state_nxt;
    logic [N-1:0]    w_gnt_nxt;
    logic [ID_W-1:0] w_gnt_id_nxt;
    logic            w_timeout_nxt;
    logic [ID_W-1:0] w_ptr_nxt;
    logic [HC_W-1:0] w_hold_nxt;
    logic            w_win_found;
    logic [ID_W-1:0] w_win_id;
    logic            w_owner_req;
    logic            w_expire;
    logic            w_rel;
    logic [ID_W-1:0] w_ptr_inc;

    // First requester at or after r_ptr, wrapping modulo N.
    always_comb begin : p_arb
        int k;
        k           = 0;
        w_win_found = 1'b0;
        w_win_id    = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(r_ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!w_win_found && i_req[k[ID_W-1:0]]) begin
                w_win_found = 1'b1;
                w_win_id    = k[ID_W-1:0];
            end
        end
    end

    assign w_owner_req = i_req[r_gnt_id];
    assign w_expire    = (r_hold_cnt == HOLD_LAST);
    assign w_rel       = i_done | ~w_owner_req | w_expire;
    assign w_ptr_inc   = (r_gnt_id == ID_LAST) ? '0 : r_gnt_id + 1'b1;

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_gnt_vld  <= 1'b0;
            r_gnt_id   <= '0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_gnt_vld  <= |w_gnt_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_timeout  <= w_timeout_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next-state logic. GAP lasts one cycle and arbitrates like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE,
            S_GAP:   w_state_nxt = w_win_found ? S_OWN : S_IDLE;
            S_OWN:   w_state_nxt = w_rel ? S_GAP : S_OWN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping.
    always_comb begin
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_timeout_nxt = 1'b0;
        unique case (r_state)
            S_IDLE,
            S_GAP: begin
                if (w_win_found) begin
                    w_gnt_nxt    = ONE << w_win_id;
                    w_gnt_id_nxt = w_win_id;
                    w_hold_nxt   = '0;
                end else begin
                    w_gnt_nxt = '0;
                end
            end
            S_OWN: begin
                if (w_rel) begin
                    w_gnt_nxt = '0;
                    w_ptr_nxt = w_ptr_inc;
                    // Expiry only counts as a timeout when nothing else
                    // would have released the owner this cycle.
                    w_timeout_nxt = w_expire & ~i_done & w_owner_req;
                end else if (!w_expire) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            default: begin
                w_gnt_nxt = '0;
            end
        endcase
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_vld = r_gnt_vld;
    assign o_gnt_id  = r_gnt_id;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_resource_sched.sv
// Bench for rr_resource_sched (N=4, MAX_HOLD=8).
// Per-cycle vector table; expected outputs queued and checked next cycle.
module tb_rr_resource_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_id;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    rr_resource_sched #(
        .N        (4),
        .MAX_HOLD (8)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_done    (done),
        .o_gnt     (gnt),
        .o_gnt_vld (gnt_vld),
        .o_gnt_id  (gnt_id),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       to;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic       vld;
        logic [1:0] id;
        logic       to;
        int         row;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    // Inputs for one cycle and outputs expected after that cycle's edge.
    function automatic void v(input logic r, input logic [3:0] rq,
                              input logic d, input logic [3:0] g,
                              input logic [1:0] id, input logic to);
        vec_t t;
        t.rst_n = r;
        t.req   = rq;
        t.done  = d;
        t.gnt   = g;
        t.id    = id;
        t.to    = to;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s row %0d: got %0h expected %0h",
                     name, row, act, exp);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        e = exp_q.pop_front();
        chk("gnt", e.row, 32'(gnt), 32'(e.gnt));
        chk("gnt_vld", e.row, 32'(gnt_vld), 32'(e.vld));
        chk("gnt_id", e.row, 32'(gnt_id), 32'(e.id));
        chk("timeout", e.row, 32'(timeout), 32'(e.to));
        chk("onehot0", e.row, 32'($onehot0(gnt)), 32'd1);
        chk("vld_eq_or", e.row, 32'(gnt_vld), 32'(|gnt));
        if (gnt_vld === 1'b1) begin
            chk("gnt_vs_id", e.row, 32'(gnt), 32'(4'b0001 << gnt_id));
        end
    endtask

    task automatic seq_reset_single();
        v(0, 4'hF, 0, 4'h0, 2'd0, 0);
        v(0, 4'hF, 0, 4'h0, 2'd0, 0);
        v(1, 4'h0, 0, 4'h0, 2'd0, 0);
        v(1, 4'h4, 0, 4'h4, 2'd2, 0);
        v(1, 4'h4, 0, 4'h4, 2'd2, 0);
        v(1, 4'h4, 0, 4'h4, 2'd2, 0);
        v(1, 4'h4, 1, 4'h0, 2'd2, 0);
        v(1, 4'h0, 0, 4'h0, 2'd2, 0);
        // ptr must now be 3: {1,3} requesting picks 3, not 1
        v(1, 4'hA, 0, 4'h8, 2'd3, 0);
        v(1, 4'hA, 1, 4'h0, 2'd3, 0);
        v(1, 4'h0, 0, 4'h0, 2'd3, 0);
    endtask

    task automatic seq_round_robin();
        for (int i = 0; i < 5; i++) begin
            logic [1:0] id;
            logic [3:0] oh;
            id = 2'(i);
            oh = 4'b0001 << id;
            if (i != 0) begin
                v(1, 4'hF, 0, oh, id, 0);
            end else begin
                v(1, 4'hF, 0, oh, id, 0);
            end
            v(1, 4'hF, 0, oh, id, 0);
            v(1, 4'hF, 1, 4'h0, id, 0);
        end
        // done outside OWN is ignored
        v(1, 4'h0, 1, 4'h0, 2'd0, 0);
        v(1, 4'h2, 1, 4'h2, 2'd1, 0);
    endtask

    task automatic seq_timeout();
        for (int i = 0; i < 7; i++) v(1, 4'h2, 0, 4'h2, 2'd1, 0);
        v(1, 4'h2, 0, 4'h0, 2'd1, 1);
        v(1, 4'h2, 0, 4'h2, 2'd1, 0);
        // done coincident with expiry: plain release
        for (int i = 0; i < 7; i++) v(1, 4'h2, 0, 4'h2, 2'd1, 0);
        v(1, 4'h2, 1, 4'h0, 2'd1, 0);
        v(1, 4'h0, 0, 4'h0, 2'd1, 0);
    endtask

    task automatic seq_abandon_reset();
        v(1, 4'hC, 0, 4'h4, 2'd2, 0);
        v(1, 4'hD, 0, 4'h4, 2'd2, 0);
        v(1, 4'hF, 0, 4'h4, 2'd2, 0);
        v(1, 4'hC, 0, 4'h4, 2'd2, 0);
        v(1, 4'h8, 0, 4'h0, 2'd2, 0);
        v(1, 4'h8, 0, 4'h8, 2'd3, 0);
        v(1, 4'h8, 0, 4'h8, 2'd3, 0);
        v(1, 4'h8, 0, 4'h8, 2'd3, 0);
        v(1, 4'h8, 0, 4'h8, 2'd3, 0);
        v(0, 4'h8, 0, 4'h0, 2'd0, 0);
        v(1, 4'h9, 0, 4'h1, 2'd0, 0);
        v(1, 4'h9, 1, 4'h0, 2'd0, 0);
        v(1, 4'h9, 0, 4'h8, 2'd3, 0);
        v(1, 4'h9, 1, 4'h0, 2'd3, 0);
        v(1, 4'h9, 0, 4'h1, 2'd0, 0);
        v(1, 4'h0, 0, 4'h0, 2'd0, 0);
        v(1, 4'h0, 0, 4'h0, 2'd0, 0);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        req   = 4'hF;
        done  = 1'b0;

        seq_reset_single();
        seq_round_robin();
        seq_timeout();
        seq_abandon_reset();

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            if (exp_q.size() > 0) compare_pop();
            rst_n = vecs[k].rst_n;
            req   = vecs[k].req;
            done  = vecs[k].done;
            e.gnt = vecs[k].gnt;
            e.vld = (vecs[k].gnt != 4'h0);
            e.id  = vecs[k].id;
            e.to  = vecs[k].to;
            e.row = k;
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (exp_q.size() > 0) compare_pop();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
